// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit processed per edge, WIDTH edges total
// DONE  | diff/bout valid, done pulses; start here chains the next operation
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-2:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x  (opa[0]),
        .y  (opb[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Counter is exactly wide enough for WIDTH-1; compare at that width so power-of-two WIDTH cannot wrap early.
    assign last     = (cnt == CW'(WIDTH - 1));
    assign res_next = {cell_d, res};

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? SHIFT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa <= a;
                        opb <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    brw <= cell_bo;
                    res <= res_next[WIDTH-1:1];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff <= res_next;
                        bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
                        ovf  <= brw ^ cell_bo;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
